// File: rtl/clause_store.sv
// Clause memory: NUM_LIT x LIT_W literals per address, per-literal write mask, 1-cycle registered read
// with same-address write forwarding; hardware clear sequencer holds ready low (ops ignored) for DEPTH cycles.
module clause_store #(
   parameter int NUM_LIT = 20,
   parameter int LIT_W   = 24,
   parameter int DEPTH   = 2048,
   parameter int ADDR_W  = $clog2(DEPTH)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clear,
   output logic                      busy,
   output logic                      ready,
   input  logic                      rd_en,
   input  logic [ADDR_W-1:0]         rd_addr,
   output logic                      rd_valid,
   output logic [NUM_LIT*LIT_W-1:0]  rd_data,
   input  logic                      wr_en,
   input  logic [ADDR_W-1:0]         wr_addr,
   input  logic [NUM_LIT*LIT_W-1:0]  wr_data,
   input  logic [NUM_LIT-1:0]        wr_lit_mask
);

   localparam int DW = NUM_LIT * LIT_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic {CLEAR, IDLE} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
   logic [DW-1:0]       mem [DEPTH];

   logic                mem_we;
   logic [ADDR_W-1:0]   mem_addr;
   logic [DW-1:0]       mem_wdata;
   logic [NUM_LIT-1:0]  mem_mask;
   logic                rd_go;
   logic [DW-1:0]       rd_next;

   assign busy  = (state_q == CLEAR);
   assign ready = ~busy;
   assign rd_go = rd_en & ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= CLEAR;
         clr_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
      end
   end

   // The sequencer owns the write port while clearing; user ops are dropped.
   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      mem_we     = 1'b0;
      mem_addr   = wr_addr;
      mem_wdata  = wr_data;
      mem_mask   = wr_lit_mask;
      case (state_q)
         CLEAR: begin
            mem_we    = 1'b1;
            mem_addr  = clr_addr_q;
            mem_wdata = '0;
            mem_mask  = '1;
            if (clr_addr_q == LAST_ADDR) begin
               state_d    = IDLE;
               clr_addr_d = '0;
            end else begin
               clr_addr_d = clr_addr_q + ADDR_W'(1);
            end
         end
         IDLE: begin
            mem_we = wr_en;
            if (clear) begin
               state_d    = CLEAR;
               clr_addr_d = '0;
            end
         end
         default: begin
            state_d    = CLEAR;
            clr_addr_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < NUM_LIT; i++) begin
            if (mem_mask[i]) mem[mem_addr][i*LIT_W +: LIT_W] <= mem_wdata[i*LIT_W +: LIT_W];
         end
      end
   end

   // Same-address forwarding returns the merged post-write clause.
   always_comb begin
      rd_next = mem[rd_addr];
      if (wr_en && (wr_addr == rd_addr)) begin
         for (int i = 0; i < NUM_LIT; i++) begin
            if (wr_lit_mask[i]) rd_next[i*LIT_W +: LIT_W] = wr_data[i*LIT_W +: LIT_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= rd_go;
         if (rd_go) rd_data <= rd_next;
      end
   end

endmodule

// File: tb/tb_clause_store.sv
// Self-checking bench for clause_store (DEPTH=16): vector table, directed clear/reset sequences,
// and randomized traffic against a literal-level reference model.
module tb_clause_store;

   localparam int NUM_LIT = 20;
   localparam int LIT_W   = 24;
   localparam int DEPTH   = 16;
   localparam int ADDR_W  = 4;
   localparam int DW      = NUM_LIT * LIT_W;

   logic                clk = 1'b0;
   logic                rst_n = 1'b1;
   logic                clear = 1'b0;
   logic                rd_en = 1'b0;
   logic                wr_en = 1'b0;
   logic [ADDR_W-1:0]   rd_addr = '0;
   logic [ADDR_W-1:0]   wr_addr = '0;
   logic [DW-1:0]       wr_data = '0;
   logic [NUM_LIT-1:0]  wr_lit_mask = '0;
   logic                busy, ready, rd_valid;
   logic [DW-1:0]       rd_data;

   clause_store #(.NUM_LIT(NUM_LIT), .LIT_W(LIT_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .busy(busy), .ready(ready),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_lit_mask(wr_lit_mask)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Reference model: clause contents, cycles of clearing left, last returned clause.
   logic [DW-1:0] model [DEPTH];
   int            busy_left;
   logic [DW-1:0] exp_rd;
   logic          exp_v;

   function automatic logic [LIT_W-1:0] get_lit(input logic [DW-1:0] c, input int k);
      return c[(NUM_LIT-1-k)*LIT_W +: LIT_W];
   endfunction

   function automatic logic [DW-1:0] put_lit(input logic [DW-1:0] c, input int k, input logic [LIT_W-1:0] v);
      logic [DW-1:0] r;
      r = c;
      r[(NUM_LIT-1-k)*LIT_W +: LIT_W] = v;
      return r;
   endfunction

   function automatic logic [DW-1:0] rep(input logic [LIT_W-1:0] v);
      logic [DW-1:0] r;
      r = '0;
      for (int k = 0; k < NUM_LIT; k++) r = put_lit(r, k, v);
      return r;
   endfunction

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0b expected %0b", name, act, exp);
      end
   endtask

   task automatic chkv(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chki(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_zero();
      for (int a = 0; a < DEPTH; a++) model[a] = '0;
   endtask

   // Apply one cycle of inputs, advance the model, and compare all outputs after the edge.
   task automatic drive_edge(input logic we, input logic [ADDR_W-1:0] wa, input logic [DW-1:0] wd,
                             input logic [NUM_LIT-1:0] wm, input logic re, input logic [ADDR_W-1:0] ra,
                             input logic clr);
      wr_en = we; wr_addr = wa; wr_data = wd; wr_lit_mask = wm;
      rd_en = re; rd_addr = ra; clear = clr;
      exp_v = 1'b0;
      if (busy_left == 0) begin
         if (we) begin
            for (int k = 0; k < NUM_LIT; k++)
               if (wm[NUM_LIT-1-k]) model[wa] = put_lit(model[wa], k, get_lit(wd, k));
         end
         if (re) begin
            exp_v  = 1'b1;
            exp_rd = model[ra];
         end
         if (clr) begin
            busy_left = DEPTH;
            model_zero();
         end
      end else begin
         busy_left--;
      end
      @(posedge clk);
      #1;
      cyc++;
      chk1($sformatf("busy@%0d", cyc), busy, busy_left > 0);
      chk1($sformatf("ready@%0d", cyc), ready, busy_left == 0);
      chk1($sformatf("rd_valid@%0d", cyc), rd_valid, exp_v);
      chkv($sformatf("rd_data@%0d", cyc), rd_data, exp_rd);
   endtask

   task automatic idle_edge();
      drive_edge(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
   endtask

   task automatic reset_pulse(input string tag);
      rst_n = 1'b0;
      #1;
      chk1({tag, "_busy"}, busy, 1'b1);
      chk1({tag, "_ready"}, ready, 1'b0);
      chk1({tag, "_rd_valid"}, rd_valid, 1'b0);
      chkv({tag, "_rd_data"}, rd_data, '0);
      wr_en = 1'b0; rd_en = 1'b0; clear = 1'b0;
      busy_left = DEPTH;
      exp_rd = '0;
      model_zero();
      #1;
      rst_n = 1'b1;
   endtask

   task automatic wait_clear(input string tag, input int already);
      int n;
      n = already;
      while (n < 64) begin
         idle_edge();
         n++;
         if (!busy) break;
      end
      chki({tag, "_clear_cycles"}, n, DEPTH);
   endtask

   typedef struct {
      logic                we;
      logic [ADDR_W-1:0]   wa;
      logic [DW-1:0]       wd;
      logic [NUM_LIT-1:0]  wm;
      logic                re;
      logic [ADDR_W-1:0]   ra;
      logic                exp_v;
      logic [DW-1:0]       exp_d;
   } vec_t;

   function automatic vec_t mk(input logic we, input logic [ADDR_W-1:0] wa, input logic [DW-1:0] wd,
                               input logic [NUM_LIT-1:0] wm, input logic re, input logic [ADDR_W-1:0] ra,
                               input logic ev, input logic [DW-1:0] ed);
      vec_t v;
      v.we = we; v.wa = wa; v.wd = wd; v.wm = wm; v.re = re; v.ra = ra; v.exp_v = ev; v.exp_d = ed;
      return v;
   endfunction

   vec_t tbl [14];

   initial begin
      logic [DW-1:0] abc_111, nine_mix, wd;
      logic [NUM_LIT-1:0] wm;
      logic [ADDR_W-1:0] wa, ra;
      abc_111  = put_lit(rep(24'hABCDEF), NUM_LIT-1, 24'h000111);
      nine_mix = put_lit(rep(24'h000022), 0, 24'h000033);
      tbl[0]  = mk(0, 0, '0, '0, 1, 0, 1, '0);
      tbl[1]  = mk(0, 0, '0, '0, 1, 7, 1, '0);
      tbl[2]  = mk(0, 0, '0, '0, 1, 15, 1, '0);
      tbl[3]  = mk(1, 5, rep(24'hABCDEF), '1, 0, 0, 0, '0);
      tbl[4]  = mk(0, 0, '0, '0, 1, 5, 1, rep(24'hABCDEF));
      tbl[5]  = mk(0, 0, '0, '0, 1, 4, 1, '0);
      tbl[6]  = mk(1, 5, rep(24'h000111), 20'h00001, 0, 0, 0, '0);
      tbl[7]  = mk(0, 0, '0, '0, 1, 5, 1, abc_111);
      tbl[8]  = mk(1, 9, rep(24'h000022), '1, 0, 0, 0, '0);
      tbl[9]  = mk(1, 9, rep(24'h000033), 20'h80000, 1, 9, 1, nine_mix);
      tbl[10] = mk(0, 0, '0, '0, 1, 9, 1, nine_mix);
      tbl[11] = mk(1, 9, rep(24'h000055), '0, 1, 9, 1, nine_mix);
      tbl[12] = mk(1, 4, rep(24'h000044), '1, 1, 5, 1, abc_111);
      tbl[13] = mk(0, 0, '0, '0, 1, 4, 1, rep(24'h000044));

      busy_left = DEPTH;
      exp_rd = '0;
      model_zero();

      // Power-on reset and initial clear.
      #1;
      reset_pulse("por");
      wait_clear("por", 0);

      // Directed vectors.
      for (int i = 0; i < 14; i++) begin
         drive_edge(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].wm, tbl[i].re, tbl[i].ra, 1'b0);
         chk1($sformatf("tbl%0d_valid", i), rd_valid, tbl[i].exp_v);
         if (tbl[i].exp_v) chkv($sformatf("tbl%0d_data", i), rd_data, tbl[i].exp_d);
      end

      // Clear with simultaneous write+read to addr 3; ops during the window are ignored.
      drive_edge(1'b1, 4'd3, rep(24'h000077), '1, 1'b1, 4'd3, 1'b1);
      chkv("clr_fwd_data", rd_data, rep(24'h000077));
      begin
         int n;
         int stray;
         n = 1;
         stray = 0;
         while (busy && n < 64) begin
            drive_edge(1'b1, 4'd0, rep(24'h000099), '1, 1'b1, ADDR_W'(n), 1'b0);
            if (rd_valid) stray++;
            n++;
         end
         chki("clr_window_cycles", n - 1, DEPTH);
         chki("clr_window_rd_valid", stray, 0);
      end
      chkv("clr_rd_data_hold", rd_data, rep(24'h000077));
      idle_edge();
      drive_edge(1'b0, '0, '0, '0, 1'b1, 4'd3, 1'b0);
      chkv("clr_addr3_zero", rd_data, '0);
      drive_edge(1'b0, '0, '0, '0, 1'b1, 4'd0, 1'b0);
      chkv("clr_addr0_zero", rd_data, '0);

      // Randomized traffic against the model.
      for (int t = 0; t < 400; t++) begin
         wa = ADDR_W'($urandom_range(0, DEPTH-1));
         ra = ($urandom_range(0, 1) == 1) ? wa : ADDR_W'($urandom_range(0, DEPTH-1));
         wd = '0;
         for (int k = 0; k < NUM_LIT; k++) wd = put_lit(wd, k, LIT_W'($urandom));
         case ($urandom_range(0, 7))
            0:       wm = '0;
            1:       wm = '1;
            default: wm = NUM_LIT'($urandom);
         endcase
         drive_edge(1'($urandom), wa, wd, wm, 1'($urandom), ra, $urandom_range(0, 99) == 0);
      end
      while (busy_left > 0) idle_edge();

      // Reset during an in-flight read strobe.
      drive_edge(1'b1, 4'd2, rep(24'h5A5A5A), '1, 1'b0, '0, 1'b0);
      drive_edge(1'b0, '0, '0, '0, 1'b1, 4'd2, 1'b0);
      chk1("midrd_valid_before", rd_valid, 1'b1);
      reset_pulse("midrd");
      wait_clear("midrd", 0);

      // Reset at clear cycle 6.
      drive_edge(1'b1, 4'd2, rep(24'h5A5A5A), '1, 1'b0, '0, 1'b0);
      drive_edge(1'b0, '0, '0, '0, 1'b1, 4'd2, 1'b1);
      chkv("midclr_rd_before", rd_data, rep(24'h5A5A5A));
      for (int c = 0; c < 5; c++) idle_edge();
      reset_pulse("midclr");
      wait_clear("midclr", 0);
      drive_edge(1'b0, '0, '0, '0, 1'b1, 4'd2, 1'b0);
      chkv("midclr_addr2_zero", rd_data, '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/clause_store.md
# clause_store

Parametrised clause memory for the WSAT solver datapath: holds one clause per address, each clause a packed vector of NUM_LIT literal slots of LIT_W bits. It generalises the fixed 20×24-bit, 2048-deep clause table. It adds per-literal write masking, a registered read with an explicit valid strobe, and same-address read-during-write forwarding. A hardware clear sequencer zeroes the whole array after reset or on request. It sits between the clause loader (writer) and the flip/break evaluators (readers).

## Interface
- NUM_LIT, 20, literal slots per clause
- LIT_W, 24, bits per literal slot
- DEPTH, 2048, number of clauses (any value ≥ 2)
- ADDR_W, $clog2(DEPTH), address width
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- clear  in  1  pulse; request zeroing of all DEPTH entries
- busy  out  1  clear sequence in progress
- ready  out  1  = !busy; rd/wr accepted only when high
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  read address
- rd_valid  out  1  one-cycle strobe: rd_data holds the requested clause
- rd_data  out  NUM_LIT*LIT_W  clause read data; literal 0 in the MSBs, literal NUM_LIT-1 in the LSBs
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  NUM_LIT*LIT_W  write clause, same packing as rd_data
- wr_lit_mask  in  NUM_LIT  bit i set → slot i is written; bit NUM_LIT-1 maps to literal 0 (MSB slot)

## Operation
- FSM states: CLEAR, IDLE.
- Async reset: enter CLEAR with clr_addr=0.
- CLEAR: each cycle write all-zero to clr_addr and increment it. When clr_addr==DEPTH-1 the write completes and the FSM goes to IDLE. Clear duration is DEPTH cycles.
- IDLE, clear=1: go to CLEAR with clr_addr=0 on the next edge.
- While busy: rd_en and wr_en are ignored (no write, no rd_valid); clear is ignored.
- Write (wr_en && ready): for each slot with a mask bit set, mem[wr_addr] slot ← wr_data slot; unmasked slots are unchanged. A zero mask is a legal no-op.
- Read (rd_en && ready): rd_data ← mem[rd_addr] at the next edge; rd_valid=1 for exactly that cycle.
- Read and write to the same address in the same accepted cycle: rd_data returns the merged post-write clause, i.e. masked slots from wr_data and unmasked slots from the old contents. Different addresses proceed independently.
- clear together with rd/wr in an IDLE cycle: the rd/wr executes that cycle and its read completes normally. The clear starts on the next edge, so the written data is subsequently zeroed.
- rd_data holds its value until the next accepted read or reset. It is not cleared by the clear sequence.
- Memory is inferred as a single registered-read array (one write, one read per cycle). During CLEAR the write port is driven by the sequencer.

## Timing
- Reset values: busy=1, ready=0, rd_valid=0, rd_data=0, FSM=CLEAR, clr_addr=0. Memory contents are undefined until the first clear completes.
- Read latency: 1 cycle from accepted rd_en to rd_valid/rd_data. Back-to-back reads every cycle give full throughput.
- A write is visible to a read accepted in the same cycle (via forwarding) and to all later reads.
- busy falls the cycle after the final clear write (address DEPTH-1). The first accepted op is on that cycle.
- Reset asserted mid-clear or mid-read: all state is restored to the reset values immediately. The clear restarts at 0 and an in-flight rd_valid is dropped.
- ready is combinational from the FSM state only; it has no path from rd_en, wr_en or clear.

## Test plan
- Reset release, DEPTH=16: busy=1 for 16 cycles, then 0. Reads of addr 0, 7 and 15 each return 0, with rd_valid 1 cycle after rd_en.
- Full write then read: write addr 5 with all literals 0xABCDEF and mask all-ones. Reading addr 5 → 0xABCDEF in every slot; reading addr 4 → 0.
- Masked write: write addr 5 with data all 0x000111 and mask 0b1 (last slot only). Read → slot NUM_LIT-1 = 0x000111; all others remain 0xABCDEF.
- Same-cycle read/write to addr 9 (old value all 0x22, new value all 0x33, mask selecting only the slot-0 bit) → rd_data slot 0 = 0x33, others = 0x22. The next read of addr 9 matches.
- clear with a simultaneous write to addr 3 → busy rises next cycle and stays high DEPTH cycles. rd_en during that window gives no rd_valid. Afterwards addr 3 reads 0.
- rst_n pulsed low at clear cycle 6 → outputs return to reset values immediately. The full DEPTH-cycle clear reruns and busy then drops.
